// File: rtl/y86_pkg.sv
// Y86 instruction encodings, register IDs and length rule shared by the
// fetch, decode and execute stages.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RESP  = 4'h4;

    // Decoded opcode and register-ID fields carried through the D->E register.
    typedef struct packed {
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } id_regs_t;

    localparam id_regs_t BUBBLE_REGS = '{
        icode: I_NOP, ifun: 4'h0, ra: RNONE, rb: RNONE,
        src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE
    };

    // Encoded length in bytes; unknown opcodes advance by one byte.
    function automatic int inst_len(input logic [3:0] icode, input int word_w);
        case (icode)
            I_HALT, I_NOP, I_RET:                 return 1;
            I_RRMOVL, I_OPL, I_PUSHL, I_POPL:     return 2;
            I_IRMOVL, I_RMMOVL, I_MRMOVL:         return 2 + word_w / 8;
            I_JXX, I_CALL:                        return 1 + word_w / 8;
            default:                              return 1;
        endcase
    endfunction

endpackage

// File: rtl/id_fields.sv
// Combinational Y86 field split: opcode/register fields, valC, valP,
// register-file source and destination selection, invalid-opcode flag.
module id_fields
    import y86_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PC_W   = 16,
    localparam int INST_W = 8 * (2 + WORD_W / 8)
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst,
    output id_regs_t          regs,
    output logic [WORD_W-1:0] val_c,
    output logic [PC_W-1:0]   val_p,
    output logic              instr_err
);

    localparam int NB = WORD_W / 8;

    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [WORD_W-1:0] imm_from_b1;
    logic [WORD_W-1:0] imm_from_b2;

    assign icode = inst[INST_W-1 -: 4];
    assign ifun  = inst[INST_W-5 -: 4];
    assign ra    = inst[INST_W-9 -: 4];
    assign rb    = inst[INST_W-13 -: 4];

    // Little-endian immediates: the lowest-addressed byte is the LSB.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_imm
            assign imm_from_b1[8*gi +: 8] = inst[INST_W-1-8*(1+gi) -: 8];
            assign imm_from_b2[8*gi +: 8] = inst[INST_W-1-8*(2+gi) -: 8];
        end
    endgenerate

    always_comb begin
        regs       = BUBBLE_REGS;
        regs.icode = icode;
        regs.ifun  = ifun;
        val_c      = '0;
        instr_err  = 1'b0;
        case (icode)
            I_HALT, I_NOP: begin
            end
            I_RRMOVL: begin
                regs.ra    = ra;
                regs.rb    = rb;
                regs.src_a = ra;
                regs.dst_e = rb;
            end
            I_IRMOVL: begin
                regs.rb    = rb;
                regs.dst_e = rb;
                val_c      = imm_from_b2;
            end
            I_RMMOVL: begin
                regs.ra    = ra;
                regs.rb    = rb;
                regs.src_a = ra;
                regs.src_b = rb;
                val_c      = imm_from_b2;
            end
            I_MRMOVL: begin
                regs.ra    = ra;
                regs.rb    = rb;
                regs.src_b = rb;
                regs.dst_m = ra;
                val_c      = imm_from_b2;
            end
            I_OPL: begin
                regs.ra    = ra;
                regs.rb    = rb;
                regs.src_a = ra;
                regs.src_b = rb;
                regs.dst_e = rb;
            end
            I_JXX: begin
                val_c = imm_from_b1;
            end
            I_CALL: begin
                regs.src_b = RESP;
                regs.dst_e = RESP;
                val_c      = imm_from_b1;
            end
            I_RET: begin
                regs.src_a = RESP;
                regs.src_b = RESP;
                regs.dst_e = RESP;
            end
            I_PUSHL: begin
                regs.ra    = ra;
                regs.src_a = ra;
                regs.src_b = RESP;
                regs.dst_e = RESP;
            end
            I_POPL: begin
                regs.ra    = ra;
                regs.src_a = RESP;
                regs.src_b = RESP;
                regs.dst_e = RESP;
                regs.dst_m = ra;
            end
            default: begin
                instr_err = 1'b1;
            end
        endcase
    end

    assign val_p = pc + PC_W'(inst_len(icode, WORD_W));

endmodule

// File: rtl/id_pipe.sv
// Y86 decode stage: field split, operand forwarding, load-use stall and the
// D->E pipeline register. Define ID_FWD_EN for value forwarding; otherwise any
// pending write to a source stalls (scoreboard mode).
module id_pipe
    import y86_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PC_W   = 16,
    parameter int NFWD   = 3,
    localparam int INST_W = 8 * (2 + WORD_W / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [INST_W-1:0]      inst_i,
    input  logic                   flush_i,
    output logic [3:0]             srcA_o,
    output logic [3:0]             srcB_o,
    input  logic [WORD_W-1:0]      rvalA_i,
    input  logic [WORD_W-1:0]      rvalB_i,
    input  logic [NFWD-1:0]        fwd_valid_i,
    input  logic [4*NFWD-1:0]      fwd_dst_i,
    input  logic [WORD_W*NFWD-1:0] fwd_val_i,
    input  logic [NFWD-1:0]        fwd_load_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             icode_o,
    output logic [3:0]             ifun_o,
    output logic [3:0]             rA_o,
    output logic [3:0]             rB_o,
    output logic [3:0]             dstE_o,
    output logic [3:0]             dstM_o,
    output logic [3:0]             srcAq_o,
    output logic [3:0]             srcBq_o,
    output logic [WORD_W-1:0]      valA_o,
    output logic [WORD_W-1:0]      valB_o,
    output logic [WORD_W-1:0]      valC_o,
    output logic [PC_W-1:0]        valP_o,
    output logic                   instr_err_o
);

    id_regs_t          dec;
    logic [WORD_W-1:0] dec_val_c;
    logic [PC_W-1:0]   dec_val_p;
    logic              dec_err;

    id_fields #(.WORD_W(WORD_W), .PC_W(PC_W)) u_fields (
        .pc        (pc_i),
        .inst      (inst_i),
        .regs      (dec),
        .val_c     (dec_val_c),
        .val_p     (dec_val_p),
        .instr_err (dec_err)
    );

    assign srcA_o = dec.src_a;
    assign srcB_o = dec.src_b;

    logic [NFWD-1:0] match_a;
    logic [NFWD-1:0] match_b;

    generate
        for (genvar gi = 0; gi < NFWD; gi++) begin : g_match
            assign match_a[gi] = fwd_valid_i[gi] && (fwd_dst_i[4*gi +: 4] == dec.src_a)
                                 && (dec.src_a != RNONE);
            assign match_b[gi] = fwd_valid_i[gi] && (fwd_dst_i[4*gi +: 4] == dec.src_b)
                                 && (dec.src_b != RNONE);
        end
    endgenerate

    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              hazard;

`ifdef ID_FWD_EN
    logic load_a;
    logic load_b;

    // Walk from oldest to youngest so the lowest-index match is the last write.
    always_comb begin
        op_a   = rvalA_i;
        op_b   = rvalB_i;
        load_a = 1'b0;
        load_b = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (match_a[i]) begin
                op_a   = fwd_val_i[WORD_W*i +: WORD_W];
                load_a = fwd_load_i[i];
            end
            if (match_b[i]) begin
                op_b   = fwd_val_i[WORD_W*i +: WORD_W];
                load_b = fwd_load_i[i];
            end
        end
    end

    assign hazard = load_a || load_b;
`else
    logic unused_fwd;

    assign unused_fwd = ^{fwd_val_i, fwd_load_i};
    assign op_a       = rvalA_i;
    assign op_b       = rvalB_i;
    assign hazard     = (|match_a) || (|match_b);
`endif

    logic              out_valid_reg;
    id_regs_t          regs_reg;
    logic [WORD_W-1:0] val_a_reg;
    logic [WORD_W-1:0] val_b_reg;
    logic [WORD_W-1:0] val_c_reg;
    logic [PC_W-1:0]   val_p_reg;
    logic              err_reg;

    logic              out_valid_next;
    id_regs_t          regs_next;
    logic [WORD_W-1:0] val_a_next;
    logic [WORD_W-1:0] val_b_next;
    logic [WORD_W-1:0] val_c_next;
    logic [PC_W-1:0]   val_p_next;
    logic              err_next;
    logic              upd;

    assign upd      = !out_valid_reg || out_ready;
    assign in_ready = upd && !hazard && !flush_i;

    // Anything other than an accepted instruction loads a bubble.
    always_comb begin
        out_valid_next = 1'b0;
        regs_next      = BUBBLE_REGS;
        val_a_next     = '0;
        val_b_next     = '0;
        val_c_next     = '0;
        val_p_next     = '0;
        err_next       = 1'b0;
        if (in_valid && in_ready) begin
            out_valid_next = 1'b1;
            regs_next      = dec;
            val_a_next     = op_a;
            val_b_next     = op_b;
            val_c_next     = dec_val_c;
            val_p_next     = dec_val_p;
            err_next       = dec_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            regs_reg      <= BUBBLE_REGS;
            val_a_reg     <= '0;
            val_b_reg     <= '0;
            val_c_reg     <= '0;
            val_p_reg     <= '0;
            err_reg       <= 1'b0;
        end else if (flush_i || upd) begin
            out_valid_reg <= out_valid_next;
            regs_reg      <= regs_next;
            val_a_reg     <= val_a_next;
            val_b_reg     <= val_b_next;
            val_c_reg     <= val_c_next;
            val_p_reg     <= val_p_next;
            err_reg       <= err_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign icode_o     = regs_reg.icode;
    assign ifun_o      = regs_reg.ifun;
    assign rA_o        = regs_reg.ra;
    assign rB_o        = regs_reg.rb;
    assign dstE_o      = regs_reg.dst_e;
    assign dstM_o      = regs_reg.dst_m;
    assign srcAq_o     = regs_reg.src_a;
    assign srcBq_o     = regs_reg.src_b;
    assign valA_o      = val_a_reg;
    assign valB_o      = val_b_reg;
    assign valC_o      = val_c_reg;
    assign valP_o      = val_p_reg;
    assign instr_err_o = err_reg;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe with hand-computed expectations; forwarding
// expectations follow whether ID_FWD_EN is defined.
module tb_id_pipe;

    localparam int WORD_W = 32;
    localparam int PC_W   = 16;
    localparam int NFWD   = 3;
    localparam int INST_W = 8 * (2 + WORD_W / 8);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [PC_W-1:0]        pc;
    logic [INST_W-1:0]      inst;
    logic                   flush;
    logic [3:0]             src_a;
    logic [3:0]             src_b;
    logic [WORD_W-1:0]      rval_a;
    logic [WORD_W-1:0]      rval_b;
    logic [NFWD-1:0]        fwd_valid;
    logic [4*NFWD-1:0]      fwd_dst;
    logic [WORD_W*NFWD-1:0] fwd_val;
    logic [NFWD-1:0]        fwd_load;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0]             icode, ifun, ra, rb, dst_e, dst_m, srcaq, srcbq;
    logic [WORD_W-1:0]      val_a, val_b, val_c;
    logic [PC_W-1:0]        val_p;
    logic                   instr_err;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [WORD_W-1:0] exp_a;

    always #5 clk = ~clk;

    id_pipe #(.WORD_W(WORD_W), .PC_W(PC_W), .NFWD(NFWD)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pc_i        (pc),
        .inst_i      (inst),
        .flush_i     (flush),
        .srcA_o      (src_a),
        .srcB_o      (src_b),
        .rvalA_i     (rval_a),
        .rvalB_i     (rval_b),
        .fwd_valid_i (fwd_valid),
        .fwd_dst_i   (fwd_dst),
        .fwd_val_i   (fwd_val),
        .fwd_load_i  (fwd_load),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .icode_o     (icode),
        .ifun_o      (ifun),
        .rA_o        (ra),
        .rB_o        (rb),
        .dstE_o      (dst_e),
        .dstM_o      (dst_m),
        .srcAq_o     (srcaq),
        .srcBq_o     (srcbq),
        .valA_o      (val_a),
        .valB_o      (val_b),
        .valC_o      (val_c),
        .valP_o      (val_p),
        .instr_err_o (instr_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        pc = '0; inst = '0; rval_a = 32'h1111; rval_b = 32'h2222;
        fwd_valid = '0; fwd_dst = '1; fwd_val = '0; fwd_load = '0;
        tick(); tick();

        $display("[TB] txn reset");
        chk("rst_valid", out_valid, 0);
        chk("rst_icode", icode, 4'h1);
        chk("rst_ifun", ifun, 4'h0);
        chk("rst_ra", ra, 4'hF);
        chk("rst_rb", rb, 4'hF);
        chk("rst_dste", dst_e, 4'hF);
        chk("rst_dstm", dst_m, 4'hF);
        chk("rst_srcaq", srcaq, 4'hF);
        chk("rst_vala", val_a, 0);
        chk("rst_valc", val_c, 0);
        chk("rst_valp", val_p, 0);
        chk("rst_err", instr_err, 0);
        rst = 1'b1;

        $display("[TB] txn irmovl $0x12345678,%%eax @0x0010");
        pc = 16'h0010; inst = 48'h30F078563412; in_valid = 1'b1;
        #1;
        chk("irm_srca_comb", src_a, 4'hF);
        chk("irm_srcb_comb", src_b, 4'hF);
        chk("irm_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("irm_valid", out_valid, 1);
        chk("irm_icode", icode, 4'h3);
        chk("irm_valc", val_c, 32'h12345678);
        chk("irm_dste", dst_e, 4'h0);
        chk("irm_dstm", dst_m, 4'hF);
        chk("irm_ra", ra, 4'hF);
        chk("irm_srcaq", srcaq, 4'hF);
        chk("irm_srcbq", srcbq, 4'hF);
        chk("irm_valp", val_p, 16'h0016);

        $display("[TB] txn addl %%ebx,%%ecx with two forwarding channels");
        pc = 16'h0016; inst = 48'h603100000000; in_valid = 1'b1;
        fwd_valid = 3'b011; fwd_dst = 12'hF33;
        fwd_val = {32'h0, 32'h0000BBBB, 32'h0000AAAA};
        #1;
        chk("add_srca_comb", src_a, 4'h3);
        chk("add_srcb_comb", src_b, 4'h1);
`ifdef ID_FWD_EN
        chk("add_ready", in_ready, 1);
        tick();
        chk("add_vala_fwd", val_a, 32'h0000AAAA);
`else
        chk("add_ready_stall", in_ready, 0);
        tick();
        chk("add_bubble", out_valid, 0);
        fwd_valid = '0;
        #1;
        chk("add_ready", in_ready, 1);
        tick();
        chk("add_vala_rf", val_a, 32'h1111);
`endif
        chk("add_valid", out_valid, 1);
        chk("add_valb", val_b, 32'h2222);
        chk("add_dste", dst_e, 4'h1);
        chk("add_srcaq", srcaq, 4'h3);
        chk("add_srcbq", srcbq, 4'h1);
        chk("add_valp", val_p, 16'h0018);
        in_valid = 1'b0; fwd_valid = '0; fwd_dst = '1;

        $display("[TB] txn load-use stall on addl %%ecx,%%edx");
        pc = 16'h0018; inst = 48'h601200000000; in_valid = 1'b1;
        fwd_valid = 3'b001; fwd_dst = 12'hFF1; fwd_load = 3'b001; fwd_val = '0;
        #1;
        chk("lu_ready0", in_ready, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lu_bubble", out_valid, 0);
            chk("lu_bubble_icode", icode, 4'h1);
            chk("lu_ready", in_ready, 0);
        end
`ifdef ID_FWD_EN
        fwd_load = '0; fwd_val = {64'h0, 32'h00000055}; exp_a = 32'h55;
`else
        fwd_valid = '0; exp_a = 32'h1111;
`endif
        #1;
        chk("lu_ready1", in_ready, 1);
        tick();
        chk("lu_valid", out_valid, 1);
        chk("lu_vala", val_a, exp_a);
        chk("lu_valb", val_b, 32'h2222);
        chk("lu_srcaq", srcaq, 4'h1);
        fwd_valid = '0; fwd_load = '0; fwd_dst = '1; fwd_val = '0;

        $display("[TB] txn backpressure then pushl %%esi @0x0020");
        out_ready = 1'b0; pc = 16'h0020; inst = 48'hA06F00000000;
        #1;
        chk("bp_ready", in_ready, 0);
        chk("push_srca_comb", src_a, 4'h6);
        chk("push_srcb_comb", src_b, 4'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_icode", icode, 4'h6);
            chk("bp_vala", val_a, exp_a);
            chk("bp_valp", val_p, 16'h001A);
            chk("bp_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("push_icode", icode, 4'hA);
        chk("push_ra", ra, 4'h6);
        chk("push_rb", rb, 4'hF);
        chk("push_srcaq", srcaq, 4'h6);
        chk("push_srcbq", srcbq, 4'h4);
        chk("push_dste", dst_e, 4'h4);
        chk("push_dstm", dst_m, 4'hF);
        chk("push_valp", val_p, 16'h0022);

        $display("[TB] txn call 0x40 @0x0020");
        pc = 16'h0020; inst = 48'h804000000000;
        tick();
        chk("call_icode", icode, 4'h8);
        chk("call_valc", val_c, 32'h40);
        chk("call_valp", val_p, 16'h0025);
        chk("call_dste", dst_e, 4'h4);
        chk("call_srcaq", srcaq, 4'hF);
        chk("call_srcbq", srcbq, 4'h4);

        $display("[TB] txn popl %%ebx @0x0025");
        pc = 16'h0025; inst = 48'hB03F00000000;
        tick();
        chk("pop_srcaq", srcaq, 4'h4);
        chk("pop_srcbq", srcbq, 4'h4);
        chk("pop_dste", dst_e, 4'h4);
        chk("pop_dstm", dst_m, 4'h3);
        chk("pop_valp", val_p, 16'h0027);

        $display("[TB] txn irmovl valP wrap @0xFFFE");
        pc = 16'hFFFE; inst = 48'h30F3EFBEADDE;
        tick();
        chk("wrap_valp", val_p, 16'h0004);
        chk("wrap_valc", val_c, 32'hDEADBEEF);
        chk("wrap_dste", dst_e, 4'h3);

        $display("[TB] txn invalid C0 @0x0030");
        pc = 16'h0030; inst = 48'hC03100000000;
        #1;
        chk("inv_srca_comb", src_a, 4'hF);
        tick();
        chk("inv_valid", out_valid, 1);
        chk("inv_err", instr_err, 1);
        chk("inv_icode", icode, 4'hC);
        chk("inv_valp", val_p, 16'h0031);
        chk("inv_ra", ra, 4'hF);
        chk("inv_dste", dst_e, 4'hF);
        chk("inv_srcaq", srcaq, 4'hF);

        $display("[TB] txn flush during accept");
        pc = 16'h0040; inst = 48'h30F078563412; flush = 1'b1;
        #1;
        chk("fl_ready", in_ready, 0);
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_err", instr_err, 0);
        flush = 1'b0;

        $display("[TB] txn reset mid-stream");
        tick();
        chk("mid_valid", out_valid, 1);
        chk("mid_valc", val_c, 32'h12345678);
        rst = 1'b0; flush = 1'b1;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_icode", icode, 4'h1);
        chk("mid_rst_valc", val_c, 0);
        chk("mid_rst_valp", val_p, 0);
        chk("mid_rst_dste", dst_e, 4'hF);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_pipe.md
# id_pipe

Registered, parametrised Y86 decode stage sitting between fetch and execute. It accepts one fetched instruction per valid/ready handshake and splits it into fields, computing valC and valP. It selects source and destination register IDs, reads the register file, resolves operands through an N-channel forwarding network, and detects load-use hazards. Results are held in a D→E pipeline register with backpressure and flush.

## Interface
- WORD_W, 32: data/immediate width (multiple of 8)
- PC_W, 16: program counter width
- NFWD, 3: forwarding channels; index 0 = youngest, highest priority
- INST_W (derived), 8*(2+WORD_W/8): fetch window width
---
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- in_valid  in  1  fetch window valid
- in_ready  out  1  stage accepts this cycle
- pc_i  in  PC_W  address of byte 0
- inst_i  in  INST_W  byte k at [INST_W-1-8k -: 8]
- flush_i  in  1  squash stage contents and current input
- srcA_o, srcB_o  out  4  combinational register-file read IDs
- rvalA_i, rvalB_i  in  WORD_W  register-file read data
- fwd_valid_i  in  NFWD  channel carries a pending write
- fwd_dst_i  in  4*NFWD  channel destination register
- fwd_val_i  in  WORD_W*NFWD  channel write value
- fwd_load_i  in  NFWD  channel value not yet available (memory load)
- out_valid  out  1  registered instruction valid
- out_ready  in  1  execute accepts
- icode_o, ifun_o, rA_o, rB_o, dstE_o, dstM_o, srcAq_o, srcBq_o  out  4 each  registered fields
- valA_o, valB_o, valC_o  out  WORD_W  registered operands
- valP_o  out  PC_W  next sequential PC
- instr_err_o  out  1  invalid icode

## Operation
- Field split: icode = byte0[7:4], ifun = byte0[3:0], rA = byte1[7:4], rB = byte1[3:0]. Immediates are little-endian.
  - valC is taken from bytes 2.. for irmovl, rmmovl, mrmovl.
  - valC is taken from bytes 1.. for jxx, call.
  - valC is 0 otherwise.
- Length rules:
  - halt, nop, ret: 1
  - rrmovl/cmovxx, opl, pushl, popl: 2
  - irmovl, rmmovl, mrmovl: 2+WORD_W/8
  - jxx, call: 1+WORD_W/8
  - valP = pc_i + length, modulo 2^PC_W.
- Unused register fields are forced to RNONE (4'hF).
- srcA:
  - rA for rrmovl, rmmovl, opl, pushl
  - RESP (4'h4) for popl, ret
- srcB:
  - rB for rmmovl, mrmovl, opl
  - RESP for pushl, popl, call, ret
- dstE:
  - rB for rrmovl/cmovxx, irmovl, opl
  - RESP for pushl, popl, call, ret
- dstM: rA for mrmovl, popl.
- All unselected source and destination IDs are RNONE.
- icode > 4'hB: instr_err_o = 1, all register IDs RNONE, valP = pc_i+1. The instruction is still passed downstream.
- Operand select, per source independently: the lowest-index channel with fwd_valid=1 and fwd_dst==src supplies the value; otherwise the register-file value is used. RNONE never matches.
- Hazard: a matching selected channel has fwd_load=1, and the source is not RNONE.
- Acceptance: in_ready = (!out_valid || out_ready) && !hazard && !flush_i.

## Timing
- Reset (rst=0 at an edge):
  - out_valid=0, icode_o=4'h1 (NOP), ifun_o=0
  - all register IDs 4'hF
  - valA/valB/valC/valP = 0, instr_err_o=0
- Latency: 1 cycle from handshake (in_valid && in_ready) to out_valid.
- Output register updates when !out_valid || out_ready. Otherwise all outputs hold stable.
- Hazard with an updatable output register: a bubble is loaded (out_valid=0, fields at reset values) and the input is not consumed. The input is re-evaluated every cycle.
- flush_i: the next edge sets out_valid=0 and the input is dropped. flush_i has priority over hold, hazard and accept.
- Reset mid-transfer discards everything. rst has priority over flush_i.
- srcA_o/srcB_o are purely combinational from inst_i. They are valid whenever in_valid=1.

## Configuration
- ID_FWD_EN defined: forwarding and load-use hazard exactly as above.
- ID_FWD_EN undefined:
  - fwd_val_i and fwd_load_i are ignored.
  - Operands always come from the register file.
  - Hazard = any channel with fwd_valid=1 whose fwd_dst equals a non-RNONE source (scoreboard stall).

## Structure
- Package y86_pkg:
  - icode constants HALT..POPL
  - RNONE, RESP
  - function inst_len(icode, WORD_W)
  - shared with fetch/execute
- Sub-module id_fields: combinational field split, valC assembly, valP, src/dst selection and instr_err. id_pipe adds forwarding, hazard and the pipeline register.

## Test plan
- irmovl $0x12345678,%eax at pc 0x0010, bytes 30 F0 78 56 34 12 → next cycle out_valid=1, valC=0x12345678, dstE=0, srcA=srcB=F, valP=0x0016.
- addl %ebx,%ecx (60 31), ch0 dst=3 val=0xAAAA, ch1 dst=3 val=0xBBBB, rvalA=0x1111 → valA=0xAAAA, valB=rvalB.
- mrmovl result pending: ch0 dst=1 load=1, input 60 12 → in_ready=0, bubble each cycle. Clear load with val=0x55 → accepted, valA=0x55.
- out_ready=0 for 3 cycles with out_valid=1 → outputs unchanged, in_ready=0. Release → next instruction loads on the same edge.
- pushl %esi (A0 6F) then call 0x00000040 (80 40 00 00 00) at pc 0x20:
  - pushl → srcA=6, srcB=4, dstE=4.
  - call → valC=0x40, valP=0x25.
- Invalid byte C0 → instr_err_o=1, valP=pc+1. flush_i during accept → out_valid=0 next cycle. rst=0 mid-stream → reset values.
